// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//  - DATA_W / PROD_W : default operand and product widths
//  - TAG_REQ0/1      : owner tags carried alongside each in-flight product
//  - rr_pick         : two-way round-robin grant function used by rr_arb2
package mult_pkg;

  localparam int   DATA_W   = 8;
  localparam int   PROD_W   = 2 * DATA_W;
  localparam logic TAG_REQ0 = 1'b0;
  localparam logic TAG_REQ1 = 1'b1;

  // One-hot grant for two requesters. On a tie the requester that did not
  // win last time is chosen, so last_gnt=1 favours requester 0.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_gnt);
    logic [1:0] gnt;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker.
// Ports:
//  clk    in   clock
//  rst_n  in   synchronous active-low reset (last grant returns to requester 1)
//  req    in   [1:0] request vector, bit N = requester N
//  en     in   arbitration enable; no grant is issued while low
//  gnt    out  [1:0] one-hot grant (combinational)
module rr_arb2
  import mult_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_gnt_r;

  // Grant decode: suppressed entirely while the pipe is frozen.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      gnt = rr_pick(req, last_gnt_r);
    end else begin
      gnt = 2'b00;
    end
  end

  // Remember the winner only when a grant actually happened, so a requester
  // that withdraws during a stall leaves the fairness pointer untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt_r <= 1'b1;
    end else if (en && (gnt != 2'b00)) begin
      last_gnt_r <= gnt[1];
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one external pipelined multiplier between two
// requesters. A tag/valid shift register tracks the owner of each product in
// the core; the head entry is steered back to its owner. If the owner of the
// head product is not ready, the whole core is frozen via mult_en.
// Ports:
//  clk, rst_n                  clock, synchronous active-low reset
//  reqN_valid/ready/a/b        operand pair handshake for requester N
//  mult_a, mult_b, mult_en     operands and stage enable to the core
//  mult_p                      product from the core's last stage
//  rspN_valid/ready            product handshake for requester N
//  rsp_p                       product shared by both responses
//  busy                        any tracked stage holds a valid product
module mult_share_arbiter #(
  parameter int DATA_W     = mult_pkg::DATA_W,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  output logic [DATA_W-1:0]   mult_a,
  output logic [DATA_W-1:0]   mult_b,
  output logic                mult_en,
  input  logic [2*DATA_W-1:0] mult_p,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [2*DATA_W-1:0] rsp_p,
  output logic                busy
);

  import mult_pkg::*;

  // Index 0 is the operand stage, index PIPE_DEPTH-1 lines up with mult_p.
  logic [PIPE_DEPTH-1:0] vld_r;
  logic [PIPE_DEPTH-1:0] tag_r;
  logic [PIPE_DEPTH-1:0] vld_nxt_s;
  logic [PIPE_DEPTH-1:0] tag_nxt_s;

  logic       head_s;
  logic       head_tag_s;
  logic       head_rdy_s;
  logic       en_s;
  logic [1:0] gnt_s;
  logic       any_gnt_s;

  assign head_s     = vld_r[PIPE_DEPTH-1];
  assign head_tag_s = tag_r[PIPE_DEPTH-1];

  // Readiness of whoever owns the product currently leaving the core.
  always_comb begin
    head_rdy_s = 1'b0;
    if (head_tag_s == TAG_REQ1) begin
      head_rdy_s = rsp1_ready;
    end else begin
      head_rdy_s = rsp0_ready;
    end
  end

  // The pipe may advance when the head is empty or is being taken this cycle.
  assign en_s    = rst_n & (~head_s | head_rdy_s);
  assign mult_en = en_s;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .en    (en_s),
    .gnt   (gnt_s)
  );

  assign any_gnt_s  = |gnt_s;
  assign req0_ready = gnt_s[0];
  assign req1_ready = gnt_s[1];

  // Operand mux; with no grant the core sees requester 0's pair.
  always_comb begin
    mult_a = req0_a;
    mult_b = req0_b;
    if (gnt_s[1]) begin
      mult_a = req1_a;
      mult_b = req1_b;
    end else begin
      mult_a = req0_a;
      mult_b = req0_b;
    end
  end

  // Next contents of the tracking shift register: new grant enters at 0.
  always_comb begin
    vld_nxt_s    = '0;
    tag_nxt_s    = '0;
    vld_nxt_s[0] = any_gnt_s;
    if (any_gnt_s) begin
      tag_nxt_s[0] = gnt_s[1] ? TAG_REQ1 : TAG_REQ0;
    end else begin
      tag_nxt_s[0] = TAG_REQ0;
    end
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      vld_nxt_s[i] = vld_r[i-1];
      tag_nxt_s[i] = tag_r[i-1];
    end
  end

  // Tracking register moves in lockstep with the core's stage enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= '0;
      tag_r <= '0;
    end else if (en_s) begin
      vld_r <= vld_nxt_s;
      tag_r <= tag_nxt_s;
    end else begin
      vld_r <= vld_r;
      tag_r <= tag_r;
    end
  end

  // Response decode; rst_n gating keeps responses quiet while reset is held.
  always_comb begin
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (rst_n && head_s) begin
      rsp0_valid = (head_tag_s == TAG_REQ0);
      rsp1_valid = (head_tag_s == TAG_REQ1);
    end else begin
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
    end
  end

  assign rsp_p = mult_p;
  assign busy  = |vld_r;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with an enabled-delay core model.
module tb_mult_share_arbiter;

  localparam int DW = 8;
  localparam int PD = 3;
  localparam int PW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, mult_a, mult_b;
  logic          mult_en;
  logic [PW-1:0] mult_p, rsp_p;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;

  always #5 clk = ~clk;

  mult_share_arbiter #(.DATA_W(DW), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_en(mult_en), .mult_p(mult_p),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_p(rsp_p), .busy(busy)
  );

  // External core: PD-stage delay of a*b, advancing only on mult_en.
  logic [PW-1:0] core_r [PD];
  always @(posedge clk) begin
    if (mult_en) begin
      core_r[0] <= PW'(mult_a) * PW'(mult_b);
      for (int i = 1; i < PD; i++) core_r[i] <= core_r[i-1];
    end
  end
  assign mult_p = core_r[PD-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue of core slots, oldest (the one at the core output) first.
  typedef struct packed {
    logic          v;
    logic          own;
    logic [PW-1:0] p;
  } slot_t;

  slot_t         slots[$];
  int            m_last;
  logic [PW-1:0] sb0[$];
  logic [PW-1:0] sb1[$];

  // Last observed outputs for directed checks.
  logic obs_en, obs_g0, obs_g1, obs_r0v, obs_r1v, obs_busy;
  logic [PW-1:0] obs_p;

  task automatic cycle(input logic rst, input logic v0, input logic [DW-1:0] a0,
                       input logic [DW-1:0] b0, input logic v1, input logic [DW-1:0] a1,
                       input logic [DW-1:0] b1, input logic r0, input logic r1, input bit chk);
    logic  head, own, e_en, e_g0, e_g1, e_busy;
    slot_t s;
    rst_n = rst; req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1; rsp0_ready = r0; rsp1_ready = r1;
    #2;
    head = slots[0].v;
    own  = slots[0].own;
    e_en = rst && (!head || (own ? r1 : r0));
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (e_en) begin
      if (v0 && v1) begin
        if (m_last == 1) e_g0 = 1'b1; else e_g1 = 1'b1;
      end else if (v0) e_g0 = 1'b1;
      else if (v1) e_g1 = 1'b1;
    end
    e_busy = 1'b0;
    foreach (slots[i]) if (slots[i].v) e_busy = 1'b1;
    obs_en = mult_en; obs_g0 = req0_ready; obs_g1 = req1_ready;
    obs_r0v = rsp0_valid; obs_r1v = rsp1_valid; obs_busy = busy; obs_p = rsp_p;
    if (chk) begin
      check_val("mult_en", 32'(mult_en), 32'(e_en));
      check_val("req0_ready", 32'(req0_ready), 32'(e_g0));
      check_val("req1_ready", 32'(req1_ready), 32'(e_g1));
      check_val("rsp0_valid", 32'(rsp0_valid), 32'(rst && head && !own));
      check_val("rsp1_valid", 32'(rsp1_valid), 32'(rst && head && own));
      check_val("busy", 32'(busy), 32'(e_busy));
      if (rst && head) check_val("rsp_p", 32'(rsp_p), 32'(slots[0].p));
      if (!e_g0 && !e_g1) begin
        check_val("mult_a_idle", 32'(mult_a), 32'(a0));
        check_val("mult_b_idle", 32'(mult_b), 32'(b0));
      end
      if (req0_valid && req0_ready) sb0.push_back(PW'(a0) * PW'(b0));
      if (req1_valid && req1_ready) sb1.push_back(PW'(a1) * PW'(b1));
      if (rsp0_valid && rsp0_ready) begin
        if (sb0.size() == 0) check_val("sb0_unexpected", 32'd1, 32'd0);
        else check_val("sb0_data", 32'(rsp_p), 32'(sb0.pop_front()));
      end
      if (rsp1_valid && rsp1_ready) begin
        if (sb1.size() == 0) check_val("sb1_unexpected", 32'd1, 32'd0);
        else check_val("sb1_data", 32'(rsp_p), 32'(sb1.pop_front()));
      end
    end
    @(posedge clk);
    if (!rst) begin
      foreach (slots[i]) slots[i] = '0;
      m_last = 1;
      sb0.delete();
      sb1.delete();
    end else if (e_en) begin
      s.v   = e_g0 | e_g1;
      s.own = e_g1;
      s.p   = e_g1 ? PW'(a1) * PW'(b1) : PW'(a0) * PW'(b0);
      void'(slots.pop_front());
      slots.push_back(s);
      if (s.v) m_last = e_g1 ? 1 : 0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < PD; i++) slots.push_back('0);
    m_last = 1;
    #1;
    // Initial reset: DUT state is unknown before the first edge, so no checks.
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    do_reset();
    check_val("reset_busy", 32'(obs_busy), 32'd0);
    check_val("reset_en", 32'(obs_en), 32'd0);

    // 1. Single req0 transaction, latency and value.
    cycle(1'b1, 1'b1, 8'd15, 8'd17, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    check_val("t1_accept", 32'(obs_g0), 32'd1);
    idle(1);
    check_val("t1_early1", 32'(obs_r0v), 32'd0);
    idle(1);
    check_val("t1_early2", 32'(obs_r0v), 32'd0);
    idle(1);
    check_val("t1_rsp0_valid", 32'(obs_r0v), 32'd1);
    check_val("t1_rsp_p", 32'(obs_p), 32'd255);
    check_val("t1_rsp1_valid", 32'(obs_r1v), 32'd0);
    idle(2);

    // 2. Both valid every cycle after reset: alternate starting with req0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 8'd255, 8'd255, 1'b1, 8'(i + 1), 8'd3, 1'b1, 1'b1, 1'b1);
      check_val("t2_gnt0", 32'(obs_g0), 32'(i % 2 == 0));
      check_val("t2_gnt1", 32'(obs_g1), 32'(i % 2 == 1));
      if (i == 3) begin
        check_val("t2_rsp0_valid", 32'(obs_r0v), 32'd1);
        check_val("t2_rsp_p", 32'(obs_p), 32'd65025);
      end
      if (i == 4) check_val("t2_rsp1_valid", 32'(obs_r1v), 32'd1);
    end
    idle(4);

    // 3. req1 product at head with its owner stalled for 4 cycles.
    cycle(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 8'd3, 8'd7, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 8'd9, 8'd9, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 8'd5, 8'd6, 1'b1, 8'd11, 8'd2, 1'b1, 1'b0, 1'b1);
      check_val("t3_en_low", 32'(obs_en), 32'd0);
      check_val("t3_no_gnt", 32'({obs_g1, obs_g0}), 32'd0);
      check_val("t3_rsp1_held", 32'(obs_r1v), 32'd1);
      check_val("t3_p_held", 32'(obs_p), 32'd21);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'(i + 20), 8'd4, 1'b1, 8'(i + 40), 8'd5, 1'b1, 1'b1, 1'b1);
    idle(4);

    // 4. Reset with three products in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'(i + 2), 8'd10, 1'b1, 8'(i + 7), 8'd10, 1'b1, 1'b1, 1'b1);
    do_reset();
    cycle(1'b1, 1'b1, 8'd4, 8'd4, 1'b1, 8'd6, 8'd6, 1'b1, 1'b1, 1'b1);
    check_val("t4_busy", 32'(obs_busy), 32'd0);
    check_val("t4_tie_gnt0", 32'(obs_g0), 32'd1);
    idle(1);
    check_val("t4_no_old_rsp", 32'({obs_r1v, obs_r0v}), 32'd0);
    idle(1);
    check_val("t4_no_old_rsp2", 32'({obs_r1v, obs_r0v}), 32'd0);
    idle(4);

    // 5. Valid on odd cycles only: responses mirror the gaps PD cycles later.
    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, (i < 10) && (i % 2 == 1), 8'(i), 8'd13, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
      check_val("t5_rsp0_gap", 32'(obs_r0v), 32'((i >= PD) && ((i - PD) % 2 == 1)));
    end
    idle(2);

    // 6. Random traffic against the model and scoreboards.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'b1, $urandom_range(0, 99) < 60, 8'($urandom), 8'($urandom),
            $urandom_range(0, 99) < 60, 8'($urandom), 8'($urandom),
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70, 1'b1);
    end
    idle(PD + 3);
    check_val("sb0_drained", 32'(sb0.size()), 32'd0);
    check_val("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
